// File: rtl/writeback_rollback_stage.sv
// Writeback / rollback stage: retires one result per cycle from the integer
// or memory pipe, drives the register-file write port, and broadcasts
// rollbacks. Per-thread squash counters discard wrong-path results that
// arrive after a rollback.
module writeback_rollback_stage #(
    parameter int THREADS_PER_CORE = 4,
    parameter int VECTOR_LANES     = 16,
    parameter int SQUASH_CYCLES    = 3,
    localparam int TW = $clog2(THREADS_PER_CORE),
    localparam int SW = $clog2(VECTOR_LANES),
    localparam int VW = 32 * VECTOR_LANES,
    localparam int CW = $clog2(SQUASH_CYCLES + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ix_instruction_valid,
    input  logic                    i_ix_has_dest,
    input  logic [4:0]              i_ix_dest_reg,
    input  logic                    i_ix_dest_is_vector,
    input  logic                    i_ix_is_last_subcycle,
    input  logic [VW-1:0]           i_ix_result,
    input  logic [VECTOR_LANES-1:0] i_ix_mask_value,
    input  logic [TW-1:0]           i_ix_thread_idx,
    input  logic                    i_ix_rollback_en,
    input  logic [31:0]             i_ix_rollback_pc,
    input  logic                    i_ix_is_eret,
    input  logic [SW-1:0]           i_ix_subcycle,
    input  logic                    i_dd_instruction_valid,
    input  logic                    i_dd_has_dest,
    input  logic [4:0]              i_dd_dest_reg,
    input  logic                    i_dd_dest_is_vector,
    input  logic                    i_dd_is_last_subcycle,
    input  logic [VW-1:0]           i_dd_result,
    input  logic [VECTOR_LANES-1:0] i_dd_mask_value,
    input  logic [TW-1:0]           i_dd_thread_idx,
    input  logic                    i_dd_rollback_en,
    input  logic [31:0]             i_dd_rollback_pc,
    input  logic [SW-1:0]           i_dd_subcycle,
    output logic                    o_wb_rollback_en,
    output logic [TW-1:0]           o_wb_rollback_thread_idx,
    output logic [31:0]             o_wb_rollback_pc,
    output logic [SW-1:0]           o_wb_rollback_subcycle,
    output logic                    o_wb_eret,
    output logic [TW-1:0]           o_wb_eret_thread_idx,
    output logic                    o_wb_writeback_en,
    output logic [TW-1:0]           o_wb_writeback_thread_idx,
    output logic                    o_wb_writeback_is_vector,
    output logic [4:0]              o_wb_writeback_reg,
    output logic [VW-1:0]           o_wb_writeback_value,
    output logic [VECTOR_LANES-1:0] o_wb_writeback_mask,
    output logic                    o_wb_retire_en,
    output logic                    o_wb_conflict
);

    logic [CW-1:0]           r_squash_count [THREADS_PER_CORE];

    logic                    w_sel_dd;
    logic                    w_live;
    logic [TW-1:0]           w_thread;
    logic                    w_has_dest;
    logic                    w_rollback;
    logic                    w_writeback;
    logic                    w_retire;
    logic                    w_eret;
    logic [31:0]             w_rollback_pc;
    logic [SW-1:0]           w_rollback_subcycle;
    logic [VW-1:0]           w_result;
    logic [VW-1:0]           w_value;
    logic [VECTOR_LANES-1:0] w_mask;
    logic                    w_is_vector;
    logic [4:0]              w_dest_reg;
    logic                    w_last;

    // Select the older (memory) pipe on a collision, apply the squash check,
    // and form the next-cycle outputs.
    always_comb begin
        w_sel_dd            = i_dd_instruction_valid;
        w_thread            = w_sel_dd ? i_dd_thread_idx : i_ix_thread_idx;
        w_live              = (i_dd_instruction_valid || i_ix_instruction_valid)
                              && (r_squash_count[w_thread] == '0);
        w_has_dest          = w_sel_dd ? i_dd_has_dest : i_ix_has_dest;
        w_dest_reg          = w_sel_dd ? i_dd_dest_reg : i_ix_dest_reg;
        w_is_vector         = w_sel_dd ? i_dd_dest_is_vector : i_ix_dest_is_vector;
        w_last              = w_sel_dd ? i_dd_is_last_subcycle : i_ix_is_last_subcycle;
        w_result            = w_sel_dd ? i_dd_result : i_ix_result;
        w_rollback          = w_live && (w_sel_dd ? i_dd_rollback_en : i_ix_rollback_en);
        w_rollback_pc       = w_sel_dd ? i_dd_rollback_pc : i_ix_rollback_pc;
        w_rollback_subcycle = w_sel_dd ? i_dd_subcycle : '0;
        // A taken branch with a link register still writes; only a load
        // that is being replayed suppresses its write and retirement.
        w_writeback         = w_live && w_has_dest && !(w_sel_dd && i_dd_rollback_en);
        w_retire            = w_live && w_last && !(w_sel_dd && i_dd_rollback_en);
        w_eret              = w_live && !w_sel_dd && i_ix_is_eret;
        w_value             = '0;
        w_mask              = '1;
        if (w_is_vector) begin
            w_value = w_result;
            w_mask  = w_sel_dd ? i_dd_mask_value : i_ix_mask_value;
        end else begin
            w_value[31:0] = w_result[31:0];
        end
    end

    // Register all outputs; unused fields are held at zero when their strobe is low.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wb_rollback_en          <= 1'b0;
            o_wb_rollback_thread_idx  <= '0;
            o_wb_rollback_pc          <= '0;
            o_wb_rollback_subcycle    <= '0;
            o_wb_eret                 <= 1'b0;
            o_wb_eret_thread_idx      <= '0;
            o_wb_writeback_en         <= 1'b0;
            o_wb_writeback_thread_idx <= '0;
            o_wb_writeback_is_vector  <= 1'b0;
            o_wb_writeback_reg        <= '0;
            o_wb_writeback_value      <= '0;
            o_wb_writeback_mask       <= '0;
            o_wb_retire_en            <= 1'b0;
            o_wb_conflict             <= 1'b0;
        end else begin
            o_wb_rollback_en          <= w_rollback;
            o_wb_rollback_thread_idx  <= w_rollback ? w_thread : '0;
            o_wb_rollback_pc          <= w_rollback ? w_rollback_pc : '0;
            o_wb_rollback_subcycle    <= w_rollback ? w_rollback_subcycle : '0;
            o_wb_eret                 <= w_eret;
            o_wb_eret_thread_idx      <= w_eret ? w_thread : '0;
            o_wb_writeback_en         <= w_writeback;
            o_wb_writeback_thread_idx <= w_writeback ? w_thread : '0;
            o_wb_writeback_is_vector  <= w_writeback && w_is_vector;
            o_wb_writeback_reg        <= w_writeback ? w_dest_reg : '0;
            o_wb_writeback_value      <= w_writeback ? w_value : '0;
            o_wb_writeback_mask       <= w_writeback ? w_mask : '0;
            o_wb_retire_en            <= w_retire;
            o_wb_conflict             <= i_ix_instruction_valid && i_dd_instruction_valid;
        end
    end

    // Squash counters: a rollback reloads its thread's counter, otherwise
    // nonzero counters count down to zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int t = 0; t < THREADS_PER_CORE; t++) begin
                r_squash_count[t] <= '0;
            end
        end else begin
            for (int t = 0; t < THREADS_PER_CORE; t++) begin
                if (w_rollback && (w_thread == TW'(t))) begin
                    r_squash_count[t] <= CW'(SQUASH_CYCLES);
                end else if (r_squash_count[t] != '0) begin
                    r_squash_count[t] <= r_squash_count[t] - 1'b1;
                end
            end
        end
    end

endmodule
